program_loader: RTL and testbench

- Boot stage directly upstream of the CPU and its instruction memory.
- Receives a program as a byte stream over a valid/ready handshake. Assembles bytes MSB-first into 32-bit instruction words and writes them into consecutive instruction-memory word slots.
- Holds the CPU in reset (active-low) until the whole program is loaded, then releases it.
- Replaces bench-side memory preloading with a synthesizable load path.

---
 rtl/program_loader.sv | 185 ++++++++++++++++++
 tb/tb_program_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: assembles a valid/ready byte stream MSB-first into 32-bit
// words, writes them to consecutive instruction-memory slots, then releases the CPU.
module program_loader #(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] MEM_WORDS = (ADDR_WIDTH+1)'(INSTR_MEM_SIZE);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [1:0]            byte_cnt_r;
    logic [ADDR_WIDTH-1:0] widx_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [31:0]           asm_r;

    logic                  byte_ready_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           mem_wdata_r;
    logic                  done_r;
    logic                  busy_r;
    logic                  error_r;

    logic                  byte_ready_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [31:0]           mem_wdata_s;
    logic                  done_s;
    logic                  busy_s;
    logic                  error_s;

    logic                  can_start_s;
    logic                  start_bad_s;
    logic                  start_zero_s;
    logic                  start_ok_s;
    logic                  xfer_s;
    logic                  last_word_s;

    assign can_start_s  = (state_r == IDLE) || (state_r == DONE);
    assign start_bad_s  = can_start_s && start && (word_count > MEM_WORDS);
    assign start_zero_s = can_start_s && start && (word_count == '0);
    assign start_ok_s   = can_start_s && start && !start_bad_s && !start_zero_s;
    assign xfer_s       = byte_ready_r && byte_valid;
    assign last_word_s  = ({1'b0, widx_r} == (count_r - (ADDR_WIDTH+1)'(1)));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_bad_s) begin
                    state_nxt_s = IDLE;
                end else if (start_zero_s) begin
                    state_nxt_s = DONE;
                end else if (start_ok_s) begin
                    state_nxt_s = RECEIVE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RECEIVE: begin
                if (xfer_s && (byte_cnt_r == 2'd3)) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = RECEIVE;
                end
            end
            WRITE: begin
                if (last_word_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RECEIVE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Byte counter, word index, latched count and assembly register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt_r <= 2'd0;
            widx_r     <= '0;
            count_r    <= '0;
            asm_r      <= 32'd0;
        end else if (start_ok_s) begin
            byte_cnt_r <= 2'd0;
            widx_r     <= '0;
            count_r    <= word_count;
        end else if (xfer_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            asm_r      <= {asm_r[23:0], byte_in};
        end else if ((state_r == WRITE) && !last_word_s) begin
            widx_r     <= widx_r + (ADDR_WIDTH)'(1);
        end else begin
            widx_r     <= widx_r;
        end
    end

    // Output decode; done/cpu_reset lag DONE entry by a cycle so the final write has
    // committed before the CPU leaves reset, but drop on the same edge that leaves DONE
    always_comb begin
        byte_ready_s = (state_nxt_s == RECEIVE);
        mem_we_s     = (state_nxt_s == WRITE);
        busy_s       = (state_nxt_s == RECEIVE) || (state_nxt_s == WRITE);
        done_s       = (state_r == DONE) && (state_nxt_s == DONE);
        if (state_nxt_s == WRITE) begin
            mem_addr_s  = widx_r;
            mem_wdata_s = {asm_r[23:0], byte_in};
        end else begin
            mem_addr_s  = mem_addr_r;
            mem_wdata_s = mem_wdata_r;
        end
        if (start_bad_s) begin
            error_s = 1'b1;
        end else if (start_ok_s || start_zero_s) begin
            error_s = 1'b0;
        end else begin
            error_s = error_r;
        end
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'd0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            byte_ready_r <= byte_ready_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            done_r       <= done_s;
            busy_r       <= busy_s;
            error_r      <= error_s;
        end
    end

    assign byte_ready = byte_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign cpu_reset  = done_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as bytes are sent,
// and a negedge monitor pops and compares every mem_we pulse.
module tb_program_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [5:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   we_cnt = 0;

    program_loader #(.INSTR_MEM_SIZE(32), .ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write pulse must match the head of the scoreboard
    always @(negedge clock) begin
        if (reset && mem_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL spurious_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(mon_e.a));
                check("wr_data", 64'(mem_wdata), 64'(mon_e.d));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            total_cnt++;
            $display("FAIL byte_timeout: got byte_ready 0 expected 1 within 50 cycles");
        end
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [4:0] a, input int gap);
        exp_t e;
        e.a = a;
        e.d = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8]);
            if (k == 1) begin
                for (int g = 0; g < gap; g++) begin
                    check("ready_in_gap", 64'(byte_ready), 64'd1);
                    @(negedge clock);
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [5:0] wc);
        start = 1'b1;
        word_count = wc;
        @(negedge clock);
        start = 1'b0;
    endtask

    // After the final byte returns: one write cycle, one gap cycle, then CPU released
    task automatic check_release(input string name);
        check({name, "_done_early"}, 64'(done), 64'd0);
        @(negedge clock);
        check({name, "_cpu_held"}, 64'(cpu_reset), 64'd0);
        @(negedge clock);
        check({name, "_done"}, {60'd0, cpu_reset, done, busy, error}, {60'd0, 4'b1100});
    endtask

    logic [31:0] prog [3];
    int          base_we;

    initial begin
        prog[0] = 32'h8C090040;
        prog[1] = 32'h01295020;
        prog[2] = 32'hAC120040;
        reset = 1'b0;
        start = 1'b0;
        word_count = 6'd0;
        byte_in = 8'd0;
        byte_valid = 1'b0;
        @(negedge clock);
        check("reset_outs", {mem_wdata, 3'd0, mem_addr, 16'd0, byte_ready, mem_we, cpu_reset, busy, done, error},
              64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Contiguous 3-word load
        pulse_start(6'd3);
        check("recv_flags", {62'd0, byte_ready, busy}, 64'd3);
        for (int i = 0; i < 3; i++) send_word(prog[i], 5'(i), 0);
        check_release("load3");

        // Reload from DONE with a 3-cycle stall between bytes 2 and 3
        pulse_start(6'd3);
        check("reload_held", {62'd0, cpu_reset, done}, 64'd0);
        for (int i = 0; i < 3; i++) send_word(prog[i], 5'(i), (i == 0) ? 3 : 0);
        check_release("gap");

        // Zero-length load from IDLE
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clock);
        base_we = we_cnt;
        pulse_start(6'd0);
        @(negedge clock);
        check("zero_done", {62'd0, cpu_reset, done}, 64'd3);

        // Oversized request from DONE falls back to IDLE with error
        pulse_start(6'd33);
        check("reject", {60'd0, error, cpu_reset, byte_ready, busy}, 64'b1000);
        check("reject_no_we", 64'(we_cnt - base_we), 64'd0);

        // Full-size load clears error and ends at addr 31
        pulse_start(6'd32);
        check("err_cleared", 64'(error), 64'd0);
        for (int i = 0; i < 32; i++) send_word({8'(i), 8'hC3, ~8'(i), 8'(i*3)}, 5'(i), 0);
        check_release("full");
        check("full_last_addr", 64'(mem_addr), 64'd31);

        // Async reset after 6 bytes: one write, everything cleared without a clock
        pulse_start(6'd3);
        base_we = we_cnt;
        send_word(prog[0], 5'd0, 0);
        send_byte(prog[1][31:24]);
        send_byte(prog[1][23:16]);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {mem_wdata, 3'd0, mem_addr, 16'd0, byte_ready, mem_we, cpu_reset, busy, done, error},
              64'd0);
        check("abort_writes", 64'(we_cnt - base_we), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pulse_start(6'd3);
        for (int i = 0; i < 3; i++) send_word(prog[2-i], 5'(i), 0);
        check_release("after_abort");

        // Reload of 2 words from DONE
        pulse_start(6'd2);
        check("re2_held", {61'd0, cpu_reset, done, busy}, 64'd1);
        send_word(32'hDEADBEEF, 5'd0, 0);
        send_word(32'h00C0FFEE, 5'd1, 0);
        check_release("re2");

        repeat (2) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
